// File: rtl/serial_adder_if.sv
// Start/done handshake bundle for serial_adder; the ovf flag exists only when
// SERIAL_ADDER_OVF_EN is defined.
interface serial_adder_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
   logic             ovf;
`endif

   modport master (
      output start, a, b, cin,
      input  busy, done, sum, cout
`ifdef SERIAL_ADDER_OVF_EN
      , input ovf
`endif
   );

   modport slave (
      input  start, a, b, cin,
      output busy, done, sum, cout
`ifdef SERIAL_ADDER_OVF_EN
      , output ovf
`endif
   );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a carry flop, LSB first, one bit per clock.
// Optional signed-overflow output is enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   serial_adder_if.slave bus
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-2:0] sum_sh_q, sum_sh_d, sum_sh_in;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             fa_s, fa_c, last_bit;
`ifdef SERIAL_ADDER_OVF_EN
   logic             ovf_q, ovf_d;
`endif

   assign fa_s     = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
   assign fa_c     = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);
   assign last_bit = (cnt_q == CW'(WIDTH - 1));

   // The first WIDTH-1 sum bits collect here; the MSB comes straight from the cell.
   generate
      if (WIDTH > 2) begin : g_sum_sh_wide
         assign sum_sh_in = {fa_s, sum_sh_q[WIDTH-2:1]};
      end else begin : g_sum_sh_single
         assign sum_sh_in = fa_s;
      end
   endgenerate

   always_comb begin
      state_d  = state_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      sum_sh_d = sum_sh_q;
      sum_d    = sum_q;
      carry_d  = carry_q;
      cout_d   = cout_q;
      cnt_d    = cnt_q;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_d    = ovf_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               a_sh_d  = bus.a;
               b_sh_d  = bus.b;
               carry_d = bus.cin;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
            b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
            carry_d  = fa_c;
            sum_sh_d = sum_sh_in;
            cnt_d    = cnt_q + 1'b1;
            if (last_bit) begin
               sum_d   = {fa_s, sum_sh_q};
               cout_d  = fa_c;
`ifdef SERIAL_ADDER_OVF_EN
               // carry_q here is the carry into the MSB
               ovf_d   = carry_q ^ fa_c;
`endif
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         sum_sh_q <= '0;
         sum_q    <= '0;
         carry_q  <= 1'b0;
         cout_q   <= 1'b0;
         cnt_q    <= '0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         sum_sh_q <= sum_sh_d;
         sum_q    <= sum_d;
         carry_q  <= carry_d;
         cout_q   <= cout_d;
         cnt_q    <= cnt_d;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q    <= ovf_d;
`endif
      end
   end

   assign bus.busy = (state_q == RUN);
   assign bus.done = (state_q == DONE);
   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
   assign bus.ovf  = ovf_q;
`endif
endmodule
